memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_pkg.sv | 62 ++++++
 rtl/memory_access_data_memory.sv | 29 ++
 rtl/memory_access.sv | 213 +++++++++++++++++++++
 tb/tb_memory_access.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared MIPS opcode defines (`OPCODE_WIDTH, `FUNCT_WIDTH, `OP_*) and memory-stage types.
// The memory_access top optionally uses MEM_ALIGN_CHECK_EN.
`ifndef MIPS_DEFINES_SVH
`define MIPS_DEFINES_SVH
`define OPCODE_WIDTH 6
`define FUNCT_WIDTH  6
`define OP_RTYPE     6'h00
`define OP_ADDI      6'h08
`define OP_LB        6'h20
`define OP_LH        6'h21
`define OP_LW        6'h23
`define OP_LBU       6'h24
`define OP_LHU       6'h25
`define OP_SB        6'h28
`define OP_SH        6'h29
`define OP_SW        6'h2B
`endif

package memory_access_pkg;

    localparam int unsigned OPW = `OPCODE_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ms_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        logic      sign_ext;
        mem_size_e size;
    } mem_op_t;

    // Classify an opcode into load/store, access size and extension.
    function automatic mem_op_t decode_op(input logic [OPW-1:0] op);
        mem_op_t d;
        d.is_load  = 1'b0;
        d.is_store = 1'b0;
        d.sign_ext = 1'b0;
        d.size     = SZ_WORD;
        case (op)
            `OP_LW:  d.is_load = 1'b1;
            `OP_LH:  begin d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SZ_HALF; end
            `OP_LHU: begin d.is_load = 1'b1; d.size = SZ_HALF; end
            `OP_LB:  begin d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SZ_BYTE; end
            `OP_LBU: begin d.is_load = 1'b1; d.size = SZ_BYTE; end
            `OP_SW:  d.is_store = 1'b1;
            `OP_SH:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
            `OP_SB:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// Word-organised data memory: byte-enabled synchronous write, combinational read.
// Contents are deliberately not reset.
module data_memory #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DWIDTH/8-1:0]   be_i,
    input  logic [AWIDTH-1:0]     addr_i,
    input  logic [DWIDTH-1:0]     wdata_i,
    output logic [DWIDTH-1:0]     rdata_c_o
);
    localparam int unsigned NB    = DWIDTH / 8;
    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/memory_access.sv
// MIPS memory stage: IDLE/BUSY wait-state FSM, byte/half lane handling, pass-through of
// non-memory results. Define MEM_ALIGN_CHECK_EN to trap misaligned LW/SW/LH/LHU/SH.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                     ms_clk,
    input  logic                     ms_rst,
    input  logic                     ms_i_ce,
    input  logic [`OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [DWIDTH-1:0]        ms_i_alu_value,
    input  logic [DWIDTH-1:0]        ms_i_data_rt,
    input  logic [4:0]               ms_i_wb_addr,
    input  logic                     ms_i_reg_write,
    output logic [DWIDTH-1:0]        ms_o_alu_value,
    output logic [DWIDTH-1:0]        ms_o_load_data,
    output logic [`OPCODE_WIDTH-1:0] ms_o_opcode,
    output logic [4:0]               ms_o_wb_addr,
    output logic                     ms_o_reg_write,
    output logic                     ms_o_ce,
    output logic                     ms_o_stall,
    output logic                     ms_o_misalign
);
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned NB = DWIDTH / 8;

    ms_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OPW-1:0]    cap_op_q, cap_op_d;
    logic [DWIDTH-1:0] cap_addr_q, cap_addr_d, cap_data_q, cap_data_d;
    logic [4:0]        cap_wb_q, cap_wb_d;
    logic              cap_rw_q, cap_rw_d;
    logic [DWIDTH-1:0] alu_q, alu_d, load_q, load_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [4:0]        wb_q, wb_d;
    logic              rw_q, rw_d, ce_q, ce_d, mis_q, mis_d;

    logic              busy_c, in_mem_c, accept_c, complete_c, misalign_c, we_c;
    logic [OPW-1:0]    acc_op_c;
    logic [DWIDTH-1:0] acc_addr_c, acc_data_c, wdata_c, rdata_c, load_c;
    logic [4:0]        acc_wb_c;
    logic              acc_rw_c;
    logic [NB-1:0]     be_c;
    logic [1:0]        lane_c;
    logic [7:0]        rbyte_c;
    logic [15:0]       rhalf_c;
    mem_op_t           in_dec_c, acc_dec_c;

    assign busy_c     = (state_q == ST_BUSY);
    assign in_dec_c   = decode_op(ms_i_opcode);
    assign in_mem_c   = in_dec_c.is_load || in_dec_c.is_store;
    assign accept_c   = !busy_c && ms_i_ce && in_mem_c;
    assign complete_c = (accept_c && (WAIT_CYCLES == 0)) || (busy_c && (cnt_q == CW'(1)));

    // Zero-wait accesses complete straight from the inputs; otherwise from the captured copy.
    assign acc_op_c   = busy_c ? cap_op_q   : ms_i_opcode;
    assign acc_addr_c = busy_c ? cap_addr_q : ms_i_alu_value;
    assign acc_data_c = busy_c ? cap_data_q : ms_i_data_rt;
    assign acc_wb_c   = busy_c ? cap_wb_q   : ms_i_wb_addr;
    assign acc_rw_c   = busy_c ? cap_rw_q   : ms_i_reg_write;
    assign acc_dec_c  = decode_op(acc_op_c);
    assign lane_c     = acc_addr_c[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = ((acc_dec_c.size == SZ_WORD) && (lane_c != 2'b00)) ||
                        ((acc_dec_c.size == SZ_HALF) && lane_c[0]);
`else
    assign misalign_c = 1'b0;
`endif

    assign we_c = complete_c && acc_dec_c.is_store && !misalign_c && ms_rst;

    // Replicate store data across lanes; byte enables pick the addressed lane(s).
    always_comb begin
        wdata_c = acc_data_c;
        be_c    = '1;
        case (acc_dec_c.size)
            SZ_BYTE: begin
                wdata_c = {NB{acc_data_c[7:0]}};
                be_c    = NB'(1) << lane_c;
            end
            SZ_HALF: begin
                wdata_c = {(NB/2){acc_data_c[15:0]}};
                be_c    = lane_c[1] ? NB'(4'b1100) : NB'(4'b0011);
            end
            default: ;
        endcase
    end

    data_memory #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_dmem (
        .clk_i     (ms_clk),
        .we_i      (we_c),
        .be_i      (be_c),
        .addr_i    (acc_addr_c[AWIDTH+1:2]),
        .wdata_i   (wdata_c),
        .rdata_c_o (rdata_c)
    );

    assign rbyte_c = rdata_c[{lane_c, 3'b000} +: 8];
    assign rhalf_c = rdata_c[{lane_c[1], 4'b0000} +: 16];

    always_comb begin
        load_c = rdata_c;
        case (acc_dec_c.size)
            SZ_BYTE: load_c = {{(DWIDTH-8){acc_dec_c.sign_ext & rbyte_c[7]}}, rbyte_c};
            SZ_HALF: load_c = {{(DWIDTH-16){acc_dec_c.sign_ext & rhalf_c[15]}}, rhalf_c};
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_op_d   = cap_op_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_wb_d   = cap_wb_q;
        cap_rw_d   = cap_rw_q;
        alu_d      = alu_q;
        load_d     = load_q;
        op_d       = op_q;
        wb_d       = wb_q;
        rw_d       = rw_q;
        mis_d      = mis_q;
        ce_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ms_i_ce && !in_mem_c) begin
                    alu_d  = ms_i_alu_value;
                    load_d = '0;
                    op_d   = ms_i_opcode;
                    wb_d   = ms_i_wb_addr;
                    rw_d   = ms_i_reg_write;
                    mis_d  = 1'b0;
                    ce_d   = 1'b1;
                end else if (accept_c && (WAIT_CYCLES > 0)) begin
                    state_d    = ST_BUSY;
                    cnt_d      = CW'(WAIT_CYCLES);
                    cap_op_d   = ms_i_opcode;
                    cap_addr_d = ms_i_alu_value;
                    cap_data_d = ms_i_data_rt;
                    cap_wb_d   = ms_i_wb_addr;
                    cap_rw_d   = ms_i_reg_write;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (complete_c) begin
            alu_d  = acc_addr_c;
            load_d = (acc_dec_c.is_load && !misalign_c) ? load_c : '0;
            op_d   = acc_op_c;
            wb_d   = acc_wb_c;
            rw_d   = acc_rw_c && !misalign_c;
            mis_d  = misalign_c;
            ce_d   = 1'b1;
        end
    end

    always_ff @(posedge ms_clk or negedge ms_rst) begin
        if (!ms_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cap_op_q   <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_wb_q   <= '0;
            cap_rw_q   <= 1'b0;
            alu_q      <= '0;
            load_q     <= '0;
            op_q       <= '0;
            wb_q       <= '0;
            rw_q       <= 1'b0;
            ce_q       <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_op_q   <= cap_op_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_wb_q   <= cap_wb_d;
            cap_rw_q   <= cap_rw_d;
            alu_q      <= alu_d;
            load_q     <= load_d;
            op_q       <= op_d;
            wb_q       <= wb_d;
            rw_q       <= rw_d;
            ce_q       <= ce_d;
            mis_q      <= mis_d;
        end
    end

    assign ms_o_alu_value = alu_q;
    assign ms_o_load_data = load_q;
    assign ms_o_opcode    = op_q;
    assign ms_o_wb_addr   = wb_q;
    assign ms_o_reg_write = rw_q;
    assign ms_o_ce        = ce_q;
    assign ms_o_misalign  = mis_q;
    assign ms_o_stall     = busy_c;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed vector table, mid-access reset, and
// randomized traffic against a byte-array reference model.
module tb_memory_access;

    localparam int unsigned WAIT = 2;
    localparam int unsigned MEMB = 1024;

    logic        ms_clk;
    logic        ms_rst;
    logic        ms_i_ce;
    logic [5:0]  ms_i_opcode;
    logic [31:0] ms_i_alu_value;
    logic [31:0] ms_i_data_rt;
    logic [4:0]  ms_i_wb_addr;
    logic        ms_i_reg_write;
    logic [31:0] ms_o_alu_value;
    logic [31:0] ms_o_load_data;
    logic [5:0]  ms_o_opcode;
    logic [4:0]  ms_o_wb_addr;
    logic        ms_o_reg_write;
    logic        ms_o_ce;
    logic        ms_o_stall;
    logic        ms_o_misalign;

    memory_access #(
        .DWIDTH      (32),
        .AWIDTH      (8),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .ms_clk         (ms_clk),
        .ms_rst         (ms_rst),
        .ms_i_ce        (ms_i_ce),
        .ms_i_opcode    (ms_i_opcode),
        .ms_i_alu_value (ms_i_alu_value),
        .ms_i_data_rt   (ms_i_data_rt),
        .ms_i_wb_addr   (ms_i_wb_addr),
        .ms_i_reg_write (ms_i_reg_write),
        .ms_o_alu_value (ms_o_alu_value),
        .ms_o_load_data (ms_o_load_data),
        .ms_o_opcode    (ms_o_opcode),
        .ms_o_wb_addr   (ms_o_wb_addr),
        .ms_o_reg_write (ms_o_reg_write),
        .ms_o_ce        (ms_o_ce),
        .ms_o_stall     (ms_o_stall),
        .ms_o_misalign  (ms_o_misalign)
    );

    initial ms_clk = 1'b0;
    always #5 ms_clk = ~ms_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [MEMB];

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_load;
        logic        exp_mis;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] ld,
                                input logic mis, input logic rw);
        vec_t v;
        v.name = n; v.op = op; v.addr = addr; v.data = data;
        v.exp_load = ld; v.exp_mis = mis; v.exp_rw = rw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            `OP_LB, `OP_LBU, `OP_SB: return 1;
            `OP_LH, `OP_LHU, `OP_SH: return 2;
            `OP_LW, `OP_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return (op == `OP_SB) || (op == `OP_SH) || (op == `OP_SW);
    endfunction

    function automatic bit model_mis(input logic [5:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        int sz = op_size(op);
        return ((sz == 2) || (sz == 4)) && ((addr % sz) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour: byte-addressed memory wrapping at MEMB bytes, naturally aligned.
    task automatic model_op(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] exp_load);
        int sz;
        int base;
        logic [63:0] v;
        sz = op_size(op);
        exp_load = '0;
        v = '0;
        if (sz == 0 || model_mis(op, addr)) return;
        base = int'(addr % MEMB);
        base = base - (base % sz);
        if (is_store(op)) begin
            for (int k = 0; k < sz; k++) mdl[base + k] = 8'(data >> (8 * k));
        end else begin
            for (int k = 0; k < sz; k++) v = v | (64'(mdl[base + k]) << (8 * k));
            if ((op == `OP_LB || op == `OP_LH) && v[8 * sz - 1])
                v = v | ~((64'd1 << (8 * sz)) - 64'd1);
            exp_load = 32'(v);
        end
    endtask

    // Present one instruction, then scramble inputs while stalled until ms_o_ce or timeout.
    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wb, input logic rw, output int edges, output int stalls);
        @(negedge ms_clk);
        ms_i_ce = 1'b1; ms_i_opcode = op; ms_i_alu_value = addr;
        ms_i_data_rt = data; ms_i_wb_addr = wb; ms_i_reg_write = rw;
        @(posedge ms_clk); #1;
        edges = 1;
        stalls = ms_o_stall ? 1 : 0;
        while (!ms_o_ce && edges < 16) begin
            @(negedge ms_clk);
            ms_i_ce = 1'($urandom); ms_i_opcode = 6'($urandom); ms_i_alu_value = $urandom;
            ms_i_data_rt = $urandom; ms_i_wb_addr = 5'($urandom); ms_i_reg_write = 1'($urandom);
            @(posedge ms_clk); #1;
            edges++;
            if (ms_o_stall) stalls++;
        end
        ms_i_ce = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] wb, input logic rw,
                             input logic [31:0] exp_load, input logic exp_mis, input logic exp_rw);
        int edges;
        int stalls;
        bit mem;
        mem = op_size(op) != 0;
        issue(op, addr, data, wb, rw, edges, stalls);
        chk({name, ".latency"}, 32'(edges), mem ? 32'(WAIT + 1) : 32'd1);
        chk({name, ".stalls"},  32'(stalls), mem ? 32'(WAIT) : 32'd0);
        chk({name, ".alu"},     ms_o_alu_value, addr);
        chk({name, ".load"},    ms_o_load_data, exp_load);
        chk({name, ".opcode"},  32'(ms_o_opcode), 32'(op));
        chk({name, ".wb_addr"}, 32'(ms_o_wb_addr), 32'(wb));
        chk({name, ".reg_wr"},  32'(ms_o_reg_write), 32'(exp_rw));
        chk({name, ".misalgn"}, 32'(ms_o_misalign), 32'(exp_mis));
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, ".alu"},     ms_o_alu_value, 32'd0);
        chk({name, ".load"},    ms_o_load_data, 32'd0);
        chk({name, ".opcode"},  32'(ms_o_opcode), 32'd0);
        chk({name, ".wb_addr"}, 32'(ms_o_wb_addr), 32'd0);
        chk({name, ".reg_wr"},  32'(ms_o_reg_write), 32'd0);
        chk({name, ".ce"},      32'(ms_o_ce), 32'd0);
        chk({name, ".stall"},   32'(ms_o_stall), 32'd0);
        chk({name, ".misalgn"}, 32'(ms_o_misalign), 32'd0);
    endtask

    logic [5:0] ops [10];

    initial begin
        int ce_seen;
        logic [5:0]  op;
        logic [31:0] addr, data, exp_load;
        logic        rw, mis;

        ms_rst = 1'b0; ms_i_ce = 1'b0; ms_i_opcode = '0; ms_i_alu_value = '0;
        ms_i_data_rt = '0; ms_i_wb_addr = '0; ms_i_reg_write = 1'b0;

        vecs.push_back(mk("pass_rtype", `OP_RTYPE, 32'h5, 32'h0, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk("sw_8",       `OP_SW,  32'h8,   32'hDEADBEEF, 32'h0,        1'b0, 1'b1));
        vecs.push_back(mk("lw_8",       `OP_LW,  32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 1'b1));
        vecs.push_back(mk("sb_9",       `OP_SB,  32'h9,   32'h80,       32'h0,        1'b0, 1'b1));
        vecs.push_back(mk("lb_9",       `OP_LB,  32'h9,   32'h0,        32'hFFFFFF80, 1'b0, 1'b1));
        vecs.push_back(mk("lbu_9",      `OP_LBU, 32'h9,   32'h0,        32'h00000080, 1'b0, 1'b1));
        vecs.push_back(mk("lw_8_b",     `OP_LW,  32'h8,   32'h0,        32'hDEAD80EF, 1'b0, 1'b1));
        vecs.push_back(mk("sh_a",       `OP_SH,  32'hA,   32'h8001,     32'h0,        1'b0, 1'b1));
        vecs.push_back(mk("lh_a",       `OP_LH,  32'hA,   32'h0,        32'hFFFF8001, 1'b0, 1'b1));
        vecs.push_back(mk("lhu_a",      `OP_LHU, 32'hA,   32'h0,        32'h00008001, 1'b0, 1'b1));
        vecs.push_back(mk("lw_alias",   `OP_LW,  32'h408, 32'h0,        32'h800180EF, 1'b0, 1'b1));
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk("lw_misalgn", `OP_LW,  32'hA,   32'h0,        32'h0,        1'b1, 1'b0));
`else
        vecs.push_back(mk("lw_misalgn", `OP_LW,  32'hA,   32'h0,        32'h800180EF, 1'b0, 1'b1));
`endif

        ops[0] = `OP_LW; ops[1] = `OP_LH; ops[2] = `OP_LHU; ops[3] = `OP_LB; ops[4] = `OP_LBU;
        ops[5] = `OP_SW; ops[6] = `OP_SH; ops[7] = `OP_SB; ops[8] = `OP_RTYPE; ops[9] = `OP_ADDI;

        repeat (3) @(posedge ms_clk);
        #1 chk_zero_outputs("reset");
        @(negedge ms_clk) ms_rst = 1'b1;

        foreach (vecs[i])
            run_check(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].data, 5'(i + 3), 1'b1,
                      vecs[i].exp_load, vecs[i].exp_mis, vecs[i].exp_rw);

        // Idle cycles must leave outputs untouched and ms_o_ce low.
        repeat (2) @(posedge ms_clk);
        #1;
        chk("hold.ce",   32'(ms_o_ce), 32'd0);
        chk("hold.alu",  ms_o_alu_value, 32'hA);
        chk("hold.load", ms_o_load_data, vecs[vecs.size() - 1].exp_load);

        // Reset in the middle of a stalled store: abort with no write and no ce pulse.
        @(negedge ms_clk);
        ms_i_ce = 1'b1; ms_i_opcode = `OP_SW; ms_i_alu_value = 32'h8;
        ms_i_data_rt = 32'h11111111; ms_i_wb_addr = 5'd1; ms_i_reg_write = 1'b0;
        @(posedge ms_clk); #1;
        ms_i_ce = 1'b0;
        chk("abort.stall1", 32'(ms_o_stall), 32'd1);
        @(posedge ms_clk); #1;
        chk("abort.stall2", 32'(ms_o_stall), 32'd1);
        #2 ms_rst = 1'b0;
        #1 chk_zero_outputs("abort_rst");
        @(posedge ms_clk);
        @(negedge ms_clk) ms_rst = 1'b1;
        ce_seen = 0;
        repeat (4) begin
            @(posedge ms_clk); #1;
            if (ms_o_ce) ce_seen++;
        end
        chk("abort.no_ce", 32'(ce_seen), 32'd0);
        run_check("abort_lw", `OP_LW, 32'h8, 32'h0, 5'd4, 1'b1, 32'h800180EF, 1'b0, 1'b1);

        // Random traffic in bytes 0x100..0x13F, with random high address bits for aliasing.
        for (int i = 0; i < 16; i++) begin
            addr = 32'h100 + 32'(4 * i);
            data = $urandom;
            model_op(`OP_SW, addr, data, exp_load);
            run_check("init_sw", `OP_SW, addr, data, 5'(i), 1'b0, exp_load, 1'b0, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            op   = ops[$urandom_range(0, 9)];
            addr = (32'h100 + 32'($urandom_range(0, 63))) | ($urandom & 32'hFFFFFC00);
            data = $urandom;
            rw   = 1'($urandom);
            mis  = (op_size(op) != 0) && model_mis(op, addr);
            model_op(op, addr, data, exp_load);
            run_check("rand", op, addr, data, 5'($urandom), rw, exp_load, mis, rw && !mis);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
